// File: rtl/shift_unit_scheduler.sv
// ============================================================================
// shift_unit_scheduler: round-robin sharing of one mantissa shifter between
// alignment (A) and normalization (B) requesters, with a one-entry response.
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_core #(
  parameter int W  = 30,
  parameter int SW = 5
) (
  input  logic [W-1:0]  data,
  input  logic [SW-1:0] amount,
  input  logic          right,
  input  logic          arith,
  output logic [W-1:0]  result,
  output logic          sticky
);
  logic [W-1:0] mask;

  always_comb begin
    mask = (W'(1) << amount) - W'(1);
    if (!right)
      result = data << amount;
    else if (arith)
      result = W'($signed(data) >>> amount);
    else
      result = data >> amount;
    sticky = right & (|(data & mask));
  end
endmodule

module shift_unit_scheduler #(
  parameter int M                   = 23,
  parameter int E                   = 8,
  parameter int EXTRA_BITS_MANTISSA = 7,
  parameter int W                   = M + EXTRA_BITS_MANTISSA
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [W-1:0] a_data,
  input  logic [E:0]   a_amount,
  input  logic         a_right,
  input  logic         a_arith,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [W-1:0] b_data,
  input  logic [E:0]   b_amount,
  input  logic         b_right,
  input  logic         b_arith,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_data,
  output logic         resp_sticky,
  output logic         resp_id,
  output logic [15:0]  op_count
);
  localparam int         SW    = $clog2(W);
  localparam logic [E:0] W_AMT = (E+1)'(W);

  typedef enum logic [0:0] {IDLE = 1'b0, FULL = 1'b1} state_t;

  state_t       state, state_next;
  logic         prefer_a;
  logic         can_accept;
  logic         grant_a, grant_b, grant;
  logic [W-1:0] sel_data;
  logic [E:0]   sel_amount;
  logic         sel_right, sel_arith;
  logic [E:0]   abs_amount;
  logic         overflow;
  logic [SW-1:0] core_amount;
  logic [W-1:0] core_result;
  logic         core_sticky;
  logic [W-1:0] shift_result;
  logic         shift_sticky;

  // A slot is free when empty, or when the held result leaves this cycle.
  assign can_accept = (state == IDLE) || resp_ready;
  assign grant_a    = can_accept && a_valid && (!b_valid || prefer_a);
  assign grant_b    = can_accept && b_valid && (!a_valid || !prefer_a);
  assign grant      = grant_a || grant_b;
  assign a_ready    = grant_a;
  assign b_ready    = grant_b;
  assign resp_valid = (state == FULL);

  assign sel_data   = grant_b ? b_data   : a_data;
  assign sel_amount = grant_b ? b_amount : a_amount;
  assign sel_right  = grant_b ? b_right  : a_right;
  assign sel_arith  = grant_b ? b_arith  : a_arith;

  // -2^E negates to itself, which read unsigned is exactly 2^E.
  assign abs_amount  = sel_amount[E] ? (~sel_amount + 1'b1) : sel_amount;
  assign overflow    = (abs_amount >= W_AMT);
  assign core_amount = overflow ? '0 : abs_amount[SW-1:0];

  shift_core #(.W(W), .SW(SW)) u_shift_core (
    .data   (sel_data),
    .amount (core_amount),
    .right  (sel_right),
    .arith  (sel_arith),
    .result (core_result),
    .sticky (core_sticky)
  );

  always_comb begin
    shift_result = core_result;
    shift_sticky = core_sticky;
    if (overflow) begin
      shift_result = (sel_right && sel_arith) ? {W{sel_data[W-1]}} : '0;
      shift_sticky = sel_right && (|sel_data);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = FULL;
      FULL:    if (resp_ready && !grant) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prefer_a    <= 1'b1;
      resp_data   <= '0;
      resp_sticky <= 1'b0;
      resp_id     <= 1'b0;
      op_count    <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        prefer_a    <= grant_b;
        resp_data   <= shift_result;
        resp_sticky <= shift_sticky;
        resp_id     <= grant_b;
      end
      if (resp_valid && resp_ready)
        op_count <= op_count + 16'd1;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_shift_unit_scheduler.sv
// ============================================================================
// tb_shift_unit_scheduler: directed vector table plus hand-written sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_shift_unit_scheduler;
  localparam int W = 30;
  localparam int E = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         a_valid = 1'b0, a_right = 1'b0, a_arith = 1'b0;
  logic [W-1:0] a_data = '0;
  logic [E:0]   a_amount = '0;
  logic         b_valid = 1'b0, b_right = 1'b0, b_arith = 1'b0;
  logic [W-1:0] b_data = '0;
  logic [E:0]   b_amount = '0;
  logic         resp_ready = 1'b0;
  logic         a_ready, b_ready, resp_valid, resp_sticky, resp_id;
  logic [W-1:0] resp_data;
  logic [15:0]  op_count;

  int n_cmp = 0;
  int n_fail = 0;

  shift_unit_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .a_amount(a_amount), .a_right(a_right), .a_arith(a_arith),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .b_amount(b_amount), .b_right(b_right), .b_arith(b_arith),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_sticky(resp_sticky),
    .resp_id(resp_id), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           port;
    logic [W-1:0] data;
    logic [E:0]   amt;
    bit           right;
    bit           arith;
    logic [W-1:0] exp_data;
    bit           exp_sticky;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit port, input logic [W-1:0] d, input logic [E:0] amt,
                       input bit r, input bit ar);
    a_valid = 1'b0;
    b_valid = 1'b0;
    if (!port) begin
      a_valid = 1'b1; a_data = d; a_amount = amt; a_right = r; a_arith = ar;
    end else begin
      b_valid = 1'b1; b_data = d; b_amount = amt; b_right = r; b_arith = ar;
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_op_count", 32'(op_count), 32'd0);
    step();
    rst_n = 1'b1;
  endtask

  logic [W-1:0] held;

  initial begin
    vecs[0]  = '{1'b0, 30'h0000_0F00, 9'd4,   1'b1, 1'b0, 30'h0000_00F0, 1'b0};
    vecs[1]  = '{1'b0, 30'h0000_000B, 9'h1FD, 1'b1, 1'b0, 30'h0000_0001, 1'b1};
    vecs[2]  = '{1'b1, 30'h2000_0001, 9'd40,  1'b1, 1'b1, 30'h3FFF_FFFF, 1'b1};
    vecs[3]  = '{1'b0, 30'h0000_0001, 9'd30,  1'b0, 1'b0, 30'h0000_0000, 1'b0};
    vecs[4]  = '{1'b1, 30'h0000_0001, 9'd29,  1'b0, 1'b0, 30'h2000_0000, 1'b0};
    vecs[5]  = '{1'b0, 30'h2000_0000, 9'd4,   1'b1, 1'b1, 30'h3E00_0000, 1'b0};
    vecs[6]  = '{1'b1, 30'h3FFF_FFFF, 9'd0,   1'b1, 1'b0, 30'h3FFF_FFFF, 1'b0};
    vecs[7]  = '{1'b0, 30'h1234_5678, 9'h100, 1'b1, 1'b0, 30'h0000_0000, 1'b1};
    vecs[8]  = '{1'b0, 30'h0000_0010, 9'h1FF, 1'b0, 1'b0, 30'h0000_0020, 1'b0};
    vecs[9]  = '{1'b1, 30'h0000_0003, 9'd1,   1'b1, 1'b0, 30'h0000_0001, 1'b1};
    vecs[10] = '{1'b0, 30'h1000_0000, 9'd29,  1'b1, 1'b0, 30'h0000_0000, 1'b1};

    // Reset state: outputs must be zero while rst_n is held low.
    step(); step();
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_data", 32'(resp_data), 32'd0);
    check("reset_resp_sticky", 32'(resp_sticky), 32'd0);
    check("reset_resp_id", 32'(resp_id), 32'd0);
    check("reset_op_count", 32'(op_count), 32'd0);
    rst_n = 1'b1;
    step();

    // Vector table: one request per cycle, consumer always ready.
    resp_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].port, vecs[i].data, vecs[i].amt, vecs[i].right, vecs[i].arith);
      #1;
      check($sformatf("v%0d_ready", i), 32'(vecs[i].port ? b_ready : a_ready), 32'd1);
      step();
      a_valid = 1'b0;
      b_valid = 1'b0;
      check($sformatf("v%0d_valid", i), 32'(resp_valid), 32'd1);
      check($sformatf("v%0d_data", i), 32'(resp_data), 32'(vecs[i].exp_data));
      check($sformatf("v%0d_sticky", i), 32'(resp_sticky), 32'(vecs[i].exp_sticky));
      check($sformatf("v%0d_id", i), 32'(resp_id), 32'(vecs[i].port));
    end
    step();
    check("vec_drain_valid", 32'(resp_valid), 32'd0);
    check("vec_op_count", 32'(op_count), 32'd11);

    // Fairness: both valid every cycle alternate A,B,A,B starting from A.
    do_reset();
    a_valid = 1'b1; a_data = 30'h100; a_amount = 9'd1; a_right = 1'b1; a_arith = 1'b0;
    b_valid = 1'b1; b_data = 30'h100; b_amount = 9'd2; b_right = 1'b0; b_arith = 1'b0;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr%0d_a_ready", k), 32'(a_ready), 32'((k % 2) == 0));
      check($sformatf("rr%0d_b_ready", k), 32'(b_ready), 32'((k % 2) == 1));
      step();
      check($sformatf("rr%0d_valid", k), 32'(resp_valid), 32'd1);
      check($sformatf("rr%0d_id", k), 32'(resp_id), 32'(k % 2));
      check($sformatf("rr%0d_data", k), 32'(resp_data), (k % 2) ? 32'h400 : 32'h80);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    step();
    check("rr_op_count", 32'(op_count), 32'd4);
    check("rr_drain_valid", 32'(resp_valid), 32'd0);

    // Backpressure: hold result, refuse both, then drain and refill with B.
    resp_ready = 1'b0;
    drive(1'b0, 30'h0000_0F00, 9'd4, 1'b1, 1'b0);
    step();
    held = resp_data;
    check("bp_first_data", 32'(held), 32'h0000_00F0);
    b_valid = 1'b1; b_data = 30'h0000_0003; b_amount = 9'd2; b_right = 1'b0; b_arith = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_a_ready", k), 32'(a_ready), 32'd0);
      check($sformatf("bp%0d_b_ready", k), 32'(b_ready), 32'd0);
      check($sformatf("bp%0d_valid", k), 32'(resp_valid), 32'd1);
      check($sformatf("bp%0d_data", k), 32'(resp_data), 32'h0000_00F0);
      step();
    end
    a_valid = 1'b0;
    resp_ready = 1'b1;
    #1;
    check("bp_refill_b_ready", 32'(b_ready), 32'd1);
    step();
    b_valid = 1'b0;
    check("bp_refill_valid", 32'(resp_valid), 32'd1);
    check("bp_refill_id", 32'(resp_id), 32'd1);
    check("bp_refill_data", 32'(resp_data), 32'h0000_000C);
    check("bp_op_count", 32'(op_count), 32'd5);

    // Reset while FULL discards the held result immediately.
    resp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(resp_valid), 32'd0);
    check("midrst_data", 32'(resp_data), 32'd0);
    check("midrst_op_count", 32'(op_count), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Counter wrap: one handshake per cycle after the first fill.
    resp_ready = 1'b1;
    drive(1'b0, 30'h1, 9'd0, 1'b0, 1'b0);
    repeat (65536) @(posedge clk);
    #1;
    check("wrap_ffff", 32'(op_count), 32'h0000_FFFF);
    step();
    check("wrap_zero", 32'(op_count), 32'd0);
    a_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/shift_unit_scheduler.md
Name: shift_unit_scheduler

Overview:
- Shares one mantissa shifter between two requesters in the FP HUB adder datapath.
  - Port A: alignment, right shift by exponent difference.
  - Port B: normalization, left shift by leading-zero count.
- Round-robin arbitration; operand and shift control delivered to an internal shifter instance.
- Shift amount normalized: absolute value, clamped to width.
- Sticky bit computed for right shifts; one-entry registered response with valid/ready handshake.

Parameters:
- M, 23, mantissa size.
- E, 8, exponent size; shift amounts are E+1 bits, two's complement.
- extra_bits_mantissa, 7, extra mantissa bits; datapath width W = M+extra_bits_mantissa.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  requester A has an operation.
- a_ready  output  1  requester A accepted this cycle.
- a_data  input  W  operand A.
- a_amount  input  E+1  signed shift amount A.
- a_right  input  1  1=right shift, 0=left shift.
- a_arith  input  1  1=arithmetic right shift.
- b_valid, b_ready, b_data, b_amount, b_right, b_arith: same as A for requester B.
- resp_valid  output  1  result register holds data.
- resp_ready  input  1  consumer accepts result.
- resp_data  output  W  shifted operand.
- resp_sticky  output  1  OR of bits shifted out (right shifts only).
- resp_id  output  1  0=A, 1=B.
- op_count  output  16  completed-response counter.

Behaviour:
- Reset (async, rst_n=0), all outputs 0:
  - resp_valid, resp_data, resp_sticky, resp_id, op_count cleared.
  - Round-robin pointer set to prefer A.
  - FSM to IDLE.
  - Asserting reset mid-operation discards the held result.
- FSM states:
  - IDLE: resp register empty.
  - FULL: resp_valid=1, waiting for resp_ready.
- Transitions:
  - IDLE to FULL when a grant occurs.
  - FULL to IDLE when resp_ready=1 and no new grant.
  - FULL stays FULL on resp_ready=1 with a new grant (back-to-back); this is the drain-and-refill case.
  - FULL holds when resp_ready=0.
- Acceptance: a grant may occur when the state is IDLE, or FULL with resp_ready=1.
- Arbitration:
  - If exactly one valid, grant it.
  - If both valid, grant the requester not granted last.
  - Pointer updates only on a grant.
  - x_ready is asserted only for the granted requester, same cycle (combinational from valids, state, resp_ready).
- Requester rule: request fields must stay stable while x_valid=1 and x_ready=0.
- Latency: 1 cycle. Grant on edge N; resp_* valid after edge N.
- Amount rule:
  - abs = |amount|, computed in E+1 bits unsigned; -2^E gives abs = 2^E.
  - If abs >= W: result is 0 for left and logical right shifts; for arithmetic right it is all copies of data[W-1].
  - Otherwise the shifter receives abs with the requester's right/arith flags.
- Sticky:
  - For right shifts, resp_sticky = OR of data[abs-1:0] (all of data if abs >= W).
  - For left shifts, resp_sticky = 0.
  - abs=0 gives sticky 0.
- resp_data, resp_sticky and resp_id stay stable while resp_valid=1 and resp_ready=0.
- op_count increments on each resp_valid & resp_ready handshake and wraps from 0xFFFF to 0.

Test Plan:
- Reset and single request:
  - Reset with rst_n=0 -> all outputs 0.
  - Then A: data=0x0000_0F00, amount=4, right=1, arith=0 -> a_ready same cycle; next cycle resp_valid=1, resp_data=0x0000_00F0, sticky=0, id=0.
- Sticky and negative amount: A: data=0x0000_000B, amount=-3 (0x1FD), right=1 -> resp_data=0x1, sticky=1.
- Arbitration fairness: A and B valid every cycle, resp_ready=1 -> grants alternate A,B,A,B with back-to-back resp_valid. After 4 responses, op_count=4.
- Backpressure:
  - resp_ready=0 with result held -> a_ready=b_ready=0; resp_data stable for 5 cycles.
  - Then resp_ready=1 and B valid -> same-cycle drain and refill; resp_id=1 on the next cycle.
- Clamping:
  - B: data=0x2000_0001, amount=40, right=1, arith=1 -> resp_data=0x3FFF_FFFF (W=30), sticky=1.
  - Left shift with amount=30 -> resp_data=0, sticky=0.
- Reset mid-operation and counter wrap:
  - rst_n low while FULL -> resp_valid=0 immediately.
  - Counter forced near wrap (65535 handshakes) -> one more handshake reads 0.
